// File: rtl/alu_issue_unit.sv
// alu_issue_unit: sequencing front end for an 8-bit combinational ALU.
// Accepts one instruction at a time over valid/ready, reads operands from an
// internal 8x8 register file, drives registered ALU inputs, and holds them for
// SETTLE_CYCLES edges before writing the ALU result back to the destination.
//
// SETTLE_CYCLES must be in 1..15. The counter is 4 bits wide, and 0 would
// underflow the settle window. DATA_W exists for readability only; the
// instruction immediate is 8 bits, so only DATA_W=8 is meaningful.
module alu_issue_unit #(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              illegal,
  input  logic [2:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // FSM encoding. The WB_DONE marker is realised by the done_q flag, so only
  // two architectural states remain.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [2:0] SEL_FWD = 3'b000;
  localparam logic [2:0] SEL_ADD = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;

  localparam logic [7:0] OPC_LOADI = 8'h00;
  localparam logic [7:0] OPC_MOV   = 8'h01;
  localparam logic [7:0] OPC_ADD   = 8'h02;
  localparam logic [7:0] OPC_SUB   = 8'h03;
  localparam logic [7:0] OPC_AND   = 8'h04;
  localparam logic [7:0] OPC_OR    = 8'h05;

  localparam int         CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  // Instruction fields
  logic [7:0]        opc;
  logic [2:0]        dest_f;
  logic [2:0]        src1_f;
  logic [2:0]        src2_f;
  logic [7:0]        imm_f;
  logic              unused_instr_bits;

  assign opc    = instr[31:24];
  assign dest_f = instr[18:16];
  assign src1_f = instr[10:8];
  assign src2_f = instr[2:0];
  assign imm_f  = instr[7:0];
  assign unused_instr_bits = ^{instr[23:19], instr[15:11]};

  // State
  logic [0:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q,   cnt_d;
  logic [DATA_W-1:0]        op1_q,   op1_d;
  logic [DATA_W-1:0]        op2_q,   op2_d;
  logic [2:0]               sel_q,   sel_d;
  logic [2:0]               dest_q,  dest_d;
  logic                     done_q,  done_d;
  logic                     ill_q,   ill_d;
  logic [7:0][DATA_W-1:0]   rf_q;
  logic                     rf_we;

  // Operand reads at the accept edge see pre-write register values, which is
  // what makes dest==src hazards use the old value.
  logic [DATA_W-1:0] rs1;
  logic [DATA_W-1:0] rs2;
  assign rs1 = rf_q[src1_f];
  assign rs2 = rf_q[src2_f];

  // Ready is forced low while reset is asserted so nothing is handshaken
  // during the reset cycle.
  assign instr_ready = rst_n & (state_q == ST_IDLE);

  assign alu_op1 = op1_q;
  assign alu_op2 = op2_q;
  assign alu_sel = sel_q;
  assign done    = done_q;
  assign illegal = ill_q;
  assign rd_data = rf_q[rd_addr];

  // Next-state: decode at acceptance, count down the settle window, retire.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sel_d   = sel_q;
    dest_d  = dest_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    rf_we   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (instr_valid) begin
        // Assume a legal opcode; the default arm below restores the held ALU
        // inputs and retires the instruction immediately as illegal.
        state_d = ST_WAIT;
        cnt_d   = CNT_INIT;
        dest_d  = dest_f;
        case (opc)
          OPC_LOADI: begin op1_d = imm_f; op2_d = '0;  sel_d = SEL_FWD; end
          OPC_MOV:   begin op1_d = rs1;   op2_d = '0;  sel_d = SEL_FWD; end
          OPC_ADD:   begin op1_d = rs1;   op2_d = rs2; sel_d = SEL_ADD; end
          OPC_SUB:   begin op1_d = rs1;   op2_d = (~rs2) + DATA_W'(1); sel_d = SEL_ADD; end
          OPC_AND:   begin op1_d = rs1;   op2_d = rs2; sel_d = SEL_AND; end
          OPC_OR:    begin op1_d = rs1;   op2_d = rs2; sel_d = SEL_OR;  end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q;
            dest_d  = dest_q;
            done_d  = 1'b1;
            ill_d   = 1'b1;
          end
        endcase
      end
    end else begin
      // Inputs are held; sample the ALU when the window has elapsed.
      if (cnt_q == '0) begin
        rf_we   = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // State registers, synchronous active-low reset. Reset aborts any
  // in-flight instruction since the writeback enable is not honoured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sel_q   <= '0;
      dest_q  <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      rf_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sel_q   <= sel_d;
      dest_q  <= dest_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      if (rf_we) rf_q[dest_q] <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit: table of instructions with expected ALU inputs
// and results, a scoreboard queue of expected retirements, plus hand-written
// sequences for ignored-valid during WAIT and reset mid-instruction.
module tb_alu_issue_unit;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  alu_op1, alu_op2;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_result;
  logic        done, illegal;
  logic [2:0]  rd_addr = '0;
  logic [7:0]  rd_data;

  alu_issue_unit #(.DATA_W(8), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_sel(alu_sel), .alu_result(alu_result), .done(done),
    .illegal(illegal), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // The external combinational ALU
  always_comb begin
    alu_result = 8'h00;
    case (alu_sel)
      3'b000: alu_result = alu_op1;
      3'b001: alu_result = alu_op1 + alu_op2;
      3'b010: alu_result = alu_op1 & alu_op2;
      3'b011: alu_result = alu_op1 | alu_op2;
      default: alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [31:0] ins;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [2:0]  sel;
    logic [7:0]  res;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [2:0] dest;
    logic [7:0] res;
    logic       ill;
  } exp_t;

  exp_t sbq[$];
  vec_t tv[11];
  logic [7:0] rf_exp[8];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [7:0] imm);
    return {op, 5'b0, d, 5'b0, s1, imm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one table entry, track it through WAIT, and score its retirement.
  task automatic run_one(input vec_t v);
    exp_t e;
    exp_t p;
    int c;
    @(negedge clk);
    chk("ready_idle", instr_ready, 1);
    instr = v.ins;
    instr_valid = 1'b1;
    e.dest = v.ins[18:16];
    e.res = v.res;
    e.ill = v.ill;
    sbq.push_back(e);
    cyc();
    instr_valid = 1'b0;
    chk("op1", alu_op1, v.op1);
    chk("op2", alu_op2, v.op2);
    chk("sel", alu_sel, v.sel);
    if (!v.ill) chk("ready_wait", instr_ready, 0);
    c = 0;
    while (!done && c < 20) begin
      chk("op1_held", alu_op1, v.op1);
      chk("sel_held", alu_sel, v.sel);
      cyc();
      c++;
    end
    chk("latency", c, v.ill ? 0 : S);
    if (done) begin
      chk("sb_depth", sbq.size(), 1);
      if (sbq.size() > 0) begin
        p = sbq.pop_front();
        chk("illegal_flag", illegal, p.ill);
        if (!p.ill) begin
          rd_addr = p.dest;
          #1;
          chk("writeback", rd_data, p.res);
        end
      end
      chk("ready_done", instr_ready, 1);
    end
    cyc();
    chk("done_pulse", done, 0);
    chk("illegal_pulse", illegal, 0);
  endtask

  initial begin
    int c;
    tv[0]  = '{mk(8'h00, 3'd1, 3'd0, 8'h05), 8'h05, 8'h00, 3'b000, 8'h05, 1'b0};
    tv[1]  = '{mk(8'h00, 3'd2, 3'd0, 8'h03), 8'h03, 8'h00, 3'b000, 8'h03, 1'b0};
    tv[2]  = '{mk(8'h02, 3'd3, 3'd1, 8'h02), 8'h05, 8'h03, 3'b001, 8'h08, 1'b0};
    tv[3]  = '{mk(8'h03, 3'd4, 3'd2, 8'h01), 8'h03, 8'hFB, 3'b001, 8'hFE, 1'b0};
    tv[4]  = '{mk(8'h00, 3'd5, 3'd0, 8'hFF), 8'hFF, 8'h00, 3'b000, 8'hFF, 1'b0};
    tv[5]  = '{mk(8'h02, 3'd6, 3'd5, 8'h05), 8'hFF, 8'hFF, 3'b001, 8'hFE, 1'b0};
    tv[6]  = '{mk(8'h04, 3'd7, 3'd1, 8'h02), 8'h05, 8'h03, 3'b010, 8'h01, 1'b0};
    tv[7]  = '{mk(8'h05, 3'd0, 3'd1, 8'h02), 8'h05, 8'h03, 3'b011, 8'h07, 1'b0};
    tv[8]  = '{mk(8'h02, 3'd1, 3'd1, 8'h01), 8'h05, 8'h05, 3'b001, 8'h0A, 1'b0};
    tv[9]  = '{mk(8'h01, 3'd2, 3'd4, 8'h00), 8'hFE, 8'h00, 3'b000, 8'hFE, 1'b0};
    // Illegal opcode: ALU inputs keep mov's values, r6 untouched
    tv[10] = '{mk(8'h3A, 3'd6, 3'd1, 8'h02), 8'hFE, 8'h00, 3'b000, 8'h00, 1'b1};
    rf_exp = '{8'h07, 8'h0A, 8'hFE, 8'h08, 8'hFE, 8'hFF, 8'hFE, 8'h01};

    // Reset state
    cyc();
    cyc();
    chk("rst_ready", instr_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_op1", alu_op1, 0);
    chk("rst_op2", alu_op2, 0);
    chk("rst_sel", alu_sel, 0);
    rd_addr = 3'd5;
    #1;
    chk("rst_rf5", rd_data, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", instr_ready, 1);

    for (int i = 0; i < 11; i++) run_one(tv[i]);

    // Register file after the illegal op
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk("rf_after_illegal", rd_data, rf_exp[i]);
    end

    // instr_valid asserted with a different instruction during WAIT is ignored
    @(negedge clk);
    instr = mk(8'h05, 3'd5, 3'd1, 8'h03);   // or r5,r1,r3 -> 0x0A|0x08
    instr_valid = 1'b1;
    cyc();
    instr = mk(8'h00, 3'd7, 3'd0, 8'h55);   // loadi r7,0x55 must be dropped
    c = 0;
    while (!done && c < 20) begin
      chk("ign_ready_wait", instr_ready, 0);
      cyc();
      c++;
    end
    instr_valid = 1'b0;
    chk("ign_latency", c, S);
    rd_addr = 3'd5;
    #1;
    chk("ign_r5", rd_data, 8'h0A);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("ign_no_done", done, 0);
    end
    rd_addr = 3'd7;
    #1;
    chk("ign_r7", rd_data, 8'h01);

    // Reset during WAIT of add r3,r1,r2 aborts it
    @(negedge clk);
    instr = mk(8'h02, 3'd3, 3'd1, 8'h02);
    instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    chk("pre_rst_sel", alu_sel, 3'b001);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_ready", instr_ready, 0);
    chk("mid_rst_op1", alu_op1, 0);
    chk("mid_rst_op2", alu_op2, 0);
    chk("mid_rst_sel", alu_sel, 0);
    chk("mid_rst_done", done, 0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ready", instr_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_done", done, 0);
      cyc();
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk("post_rst_rf", rd_data, 0);
    end

    // Unit recovers after reset
    run_one('{mk(8'h00, 3'd2, 3'd0, 8'h42), 8'h42, 8'h00, 3'b000, 8'h42, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequencing front end that drives the 8-bit combinational ALU (select codes: 000 forward op1, 001 add, 010 and, 011 or) and consumes its result.
- Accepts 32-bit instructions over a valid/ready handshake and reads operands from an internal 8x8 register file.
- Registers the ALU inputs, then holds them for a fixed settle window that covers the ALU's propagation delay.
- Writes the captured result back to the destination register. This is the initiator/consumer end of the ALU's op1/op2/s -> r interface.

Parameters:
- DATA_W, 8, operand/register width; only 8 is supported.
- SETTLE_CYCLES, 2, cycles ALU inputs are held stable before the result is sampled. Legal range is 1..15; 0 is illegal.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- instr  input  32  instruction fields: opcode[31:24], dest[18:16], src1[10:8], src2/imm[7:0] (src2 index is [2:0]).
- instr_valid  input  1  instruction present on instr.
- instr_ready  output  1  unit can accept an instruction.
- alu_op1  output  8  ALU operand 1 (registered).
- alu_op2  output  8  ALU operand 2 (registered).
- alu_sel  output  3  ALU select (registered).
- alu_result  input  8  ALU result r.
- done  output  1  one-cycle pulse when an instruction retires.
- illegal  output  1  one-cycle pulse, coincident with done, when an unknown opcode is retired.
- rd_addr  input  3  debug read index.
- rd_data  output  8  combinational read of reg[rd_addr].

Behaviour:
- Reset: the clock is clk; reset is synchronous and active-low on rst_n. It is sampled only at the rising edge of clk.
- Reset state: while rst_n=0 at an edge, all 8 registers, alu_op1, alu_op2, alu_sel, done and illegal are cleared to 0. State goes to IDLE and the settle counter clears.
- instr_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- Reset mid-instruction aborts it: no writeback and no done.
- FSM states: IDLE, WAIT, WB_DONE. WB_DONE is a transient single-cycle marker and is implementable as a flag.
- IDLE:
  - instr_ready=1.
  - On an edge with instr_valid=1, the instruction is accepted.
  - Operands are read from the register file at this edge (pre-write values).
  - alu_op1, alu_op2 and alu_sel are loaded.
  - The counter is set to SETTLE_CYCLES-1.
  - State goes to WAIT.
- Opcode decode at acceptance:
  - 0x00 loadi: op1=imm, op2=0, sel=000.
  - 0x01 mov: op1=reg[src1], op2=0, sel=000.
  - 0x02 add: op1=reg[src1], op2=reg[src2], sel=001.
  - 0x03 sub: op1=reg[src1], op2=(~reg[src2])+1 mod 256, sel=001.
  - 0x04 and: op1=reg[src1], op2=reg[src2], sel=010.
  - 0x05 or: op1=reg[src1], op2=reg[src2], sel=011.
- Other opcodes:
  - ALU outputs keep their previous values and no register is written.
  - State returns to IDLE at the accepting edge.
  - done=1 and illegal=1 in the next cycle.
- WAIT:
  - instr_ready=0 and ALU outputs are held stable.
  - The counter decrements each edge.
  - On the edge where the counter is 0: reg[dest] <= alu_result, done=1 for the following cycle, state goes to IDLE.
- Latency: acceptance edge E0, writeback edge E(SETTLE_CYCLES). done is high in the cycle after that edge.
- Back-to-back: instr_ready=1 during the done cycle, so a new instruction is accepted at the next edge. Throughput is 1 per SETTLE_CYCLES+1 cycles.
- done and illegal are single-cycle pulses and are never high for two consecutive cycles from one instruction.
- Arithmetic: all sums wrap mod 256. The ALU provides no carry or overflow, and the unit generates none.
- Hazards:
  - dest==src uses the old value, because operands are latched at acceptance.
  - rd_data reflects a write starting in the cycle after the write edge.
- instr_valid is ignored while instr_ready=0. The instruction is not queued, and the source must hold it until the handshake.

Test Plan:
- Reset then loadi r1,0x05; loadi r2,0x03 (SETTLE_CYCLES=2) -> each done exactly 2 edges after accept; rd_addr=1 gives 0x05, rd_addr=2 gives 0x03; alu_sel=000 during WAIT.
- add r3,r1,r2 -> alu_op1=0x05, alu_op2=0x03, alu_sel=001 held for 2 cycles; r3=0x08.
- sub r4,r2,r1 -> alu_op2=0xFB; r4=0xFE. Then loadi r5,0xFF; add r6,r5,r5 -> r6=0xFE (wrap).
- and r7,r1,r2 -> r7=0x01; or r0,r1,r2 -> r0=0x07. Then add r1,r1,r1 -> r1=0x0A (old operand used).
- Opcode 0x3A with instr_valid held high -> done=1 and illegal=1 for exactly one cycle; all 8 registers unchanged; instr_valid ignored while instr_ready=0.
- Assert rst_n=0 for one edge during WAIT of add r3 -> no done, r3=0x00, all outputs 0; instr_ready=1 the cycle after release.
